// File: rtl/responder_core_if.sv
// responder_core_if: key inputs and display-facing outputs of the quiz responder
interface responder_core_if;
  logic [7:0] Key_Player;
  logic       Start_Key;
  logic       Set_Key;
  logic       Add_Key;
  logic       Sub_Key;
  logic [3:0] Player_Number;
  logic [3:0] TimerH;
  logic [3:0] TimerL;
  logic [3:0] TimerH_Set;
  logic [3:0] TimerL_Set;
  logic       Set_Time;
  logic       Alarm;
  modport master (
    output Key_Player, Start_Key, Set_Key, Add_Key, Sub_Key,
    input  Player_Number, TimerH, TimerL, TimerH_Set, TimerL_Set, Set_Time, Alarm
  );
  modport slave (
    input  Key_Player, Start_Key, Set_Key, Add_Key, Sub_Key,
    output Player_Number, TimerH, TimerL, TimerH_Set, TimerL_Set, Set_Time, Alarm
  );
endinterface

// File: rtl/responder_core.sv
// responder_core: countdown timer, answer-time setting and 8-player first-press lockout
module responder_core #(
  parameter int         TICK_CYCLES   = 50000000,
  parameter logic [3:0] SET_DEFAULT_H = 4'd3,
  parameter logic [3:0] SET_DEFAULT_L = 4'd0
) (
  input logic CLK,
  input logic RST,
  responder_core_if.slave bus
);
  localparam int TW = $clog2(TICK_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, SET, RUN, LOCKED, TIMEOUT} state_t;
  state_t state, nxt;
  logic [11:0] s1, s2, prev, press;
  logic [TW-1:0] tick;
  logic [3:0] th, tl, sh, sl, pl, pnum, dh, dl;
  logic tc, tz, any_p, start_p, set_p, add_p, sub_p, set_time, alarm;
  function automatic logic [7:0] bcd_inc(input logic [3:0] h, input logic [3:0] l);
    return (l == 4'd9) ? {(h == 4'd9) ? 4'd0 : h + 4'd1, 4'd0} : {h, l + 4'd1};
  endfunction
  function automatic logic [7:0] bcd_dec(input logic [3:0] h, input logic [3:0] l);
    return (l == 4'd0) ? {(h == 4'd0) ? 4'd9 : h - 4'd1, 4'd9} : {h, l - 4'd1};
  endfunction
  // two-stage synchronizer plus previous-value stage; a press is a rising edge of the synced level
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
    end else begin
      s1 <= {bus.Sub_Key, bus.Add_Key, bus.Set_Key, bus.Start_Key, bus.Key_Player};
      s2 <= s1;
      prev <= s2;
    end
  assign press = s2 & ~prev;
  assign {sub_p, add_p, set_p, start_p} = press[11:8];
  assign any_p = |press[7:0];
  assign {dh, dl} = bcd_dec(th, tl);
  assign tz = {th, tl} == 8'h00;
  assign tc = tick == TW'(TICK_CYCLES - 1);
  // lowest-numbered player among simultaneous presses wins
  always_comb begin
    pnum = '0;
    for (int i = 7; i >= 0; i--) if (press[i]) pnum = 4'(i + 1);
  end
  // state register
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= nxt;
  // next-state logic; in RUN an abort beats a press, and a press beats the tick
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = set_p ? SET : start_p ? RUN : IDLE;
      SET:     nxt = set_p ? IDLE : SET;
      RUN:     nxt = start_p ? IDLE : any_p ? LOCKED :
                     (tz || (tc && {dh, dl} == 8'h00)) ? TIMEOUT : RUN;
      default: nxt = start_p ? IDLE : state;
    endcase
  end
  // timer, tick counter, set time and winner registers
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      tick <= '0;
      {th, tl} <= {SET_DEFAULT_H, SET_DEFAULT_L};
      {sh, sl} <= {SET_DEFAULT_H, SET_DEFAULT_L};
      pl <= '0;
    end else begin
      tick <= (state == RUN && nxt == RUN) ? (tc ? '0 : tick + 1'b1) : '0;
      {th, tl} <= (state == IDLE || state == SET) ? {sh, sl} :
                  (nxt == TIMEOUT) ? 8'h00 :
                  (state == RUN && nxt == RUN && tc) ? {dh, dl} : {th, tl};
      if (state == SET && (add_p ^ sub_p)) {sh, sl} <= add_p ? bcd_inc(sh, sl) : bcd_dec(sh, sl);
      pl <= (nxt == LOCKED) ? ((state == LOCKED) ? pl : pnum) : 4'd0;
    end
  // status flags decoded from the state register
  always_comb begin
    set_time = state == SET;
    alarm = state == TIMEOUT;
  end
  assign bus.Player_Number = pl;
  assign bus.TimerH = th;
  assign bus.TimerL = tl;
  assign bus.TimerH_Set = sh;
  assign bus.TimerL_Set = sl;
  assign bus.Set_Time = set_time;
  assign bus.Alarm = alarm;
endmodule
